// File: rtl/corr_pkt_decoder_if.sv
// corr_pkt_decoder_if
//   Bundles the byte-pipe input, the packet output handshake, the clock-gate
//   and flush controls, and the status outputs of corr_pkt_decoder.
//   slave  : decoder view (consumes bytes, produces packets/status)
//   master : environment view (produces bytes, consumes packets/status)
// Signals
//   i_cg          clock-gate enable; all decoder state holds when low
//   i_flush       synchronous resync request
//   i_bp_data     byte pipe data (8)
//   i_bp_valid    byte pipe valid
//   o_bp_ready    byte pipe ready
//   o_pkt_data    {symdiff,isect,y,x,winNum}, winNum in [7:0] (40)
//   o_pkt_seqErr  winNum discontinuity flag, qualified by o_pkt_valid
//   o_pkt_valid   packet output valid
//   i_pkt_ready   packet output ready
//   o_nDropped    saturating count of skipped windows (DROPCOUNT_W)
//   o_abort       1-cycle pulse when a partial packet times out
interface corr_pkt_decoder_if #(
  parameter int DROPCOUNT_W = 16
);
  logic                   i_cg;
  logic                   i_flush;
  logic [7:0]             i_bp_data;
  logic                   i_bp_valid;
  logic                   o_bp_ready;
  logic [39:0]            o_pkt_data;
  logic                   o_pkt_seqErr;
  logic                   o_pkt_valid;
  logic                   i_pkt_ready;
  logic [DROPCOUNT_W-1:0] o_nDropped;
  logic                   o_abort;

  modport slave (
    input  i_cg, i_flush, i_bp_data, i_bp_valid, i_pkt_ready,
    output o_bp_ready, o_pkt_data, o_pkt_seqErr, o_pkt_valid, o_nDropped, o_abort
  );

  modport master (
    output i_cg, i_flush, i_bp_data, i_bp_valid, i_pkt_ready,
    input  o_bp_ready, o_pkt_data, o_pkt_seqErr, o_pkt_valid, o_nDropped, o_abort
  );
endinterface

// File: rtl/corr_pkt_decoder.sv
// corr_pkt_decoder
//   Receiving end of the correlator result stream. Reassembles 5-byte packets
//   (winNum, countX, countY, countIsect, countSymdiff) arriving on a byte pipe
//   into one 40-bit word behind a valid/ready handshake, checks winNum
//   continuity and keeps a saturating count of skipped windows. A partial
//   packet that stalls for TIMEOUT_CYCLES is discarded with an o_abort pulse.
// Ports
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   bus     corr_pkt_decoder_if.slave (byte pipe, packet output, cg/flush, status)
//
// state | meaning
// ------+--------------------------------------------------------------
// B0    | waiting for byte 0 (winNum); no partial packet held
// B1    | winNum staged, waiting for countX
// B2    | waiting for countY
// B3    | waiting for countIsect
// B4    | waiting for countSymdiff; accepted only if output slot can take it
module corr_pkt_decoder #(
  parameter int DROPCOUNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  corr_pkt_decoder_if.slave   bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Sum width wide enough for counter + an 8-bit gap without wrapping.
  localparam int SW = ((DROPCOUNT_W > 8) ? DROPCOUNT_W : 8) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] DROP_SAT = (SW'(1) << DROPCOUNT_W) - SW'(1);

  typedef enum logic [2:0] {
    ST_B0 = 3'd0,
    ST_B1 = 3'd1,
    ST_B2 = 3'd2,
    ST_B3 = 3'd3,
    ST_B4 = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0][7:0]        stg_q, stg_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   have_last_q, have_last_d;
  logic [7:0]             last_q, last_d;
  logic                   valid_q, valid_d;
  logic [39:0]            data_q, data_d;
  logic                   seq_err_q, seq_err_d;
  logic [DROPCOUNT_W-1:0] ndrop_q, ndrop_d;
  logic                   abort_q, abort_d;

  logic                   bp_ready;
  logic                   acc;
  logic                   complete;
  logic [7:0]             win;
  logic [7:0]             win_exp;
  logic [7:0]             gap;
  logic [SW-1:0]          drop_sum;

  // Byte 4 needs the output slot: free now, or drained in this same cycle.
  always_comb begin
    bp_ready = bus.i_cg && !bus.i_flush &&
               ((state_q != ST_B4) || !valid_q || bus.i_pkt_ready);
    acc      = bus.i_cg && bus.i_bp_valid && bp_ready;
    complete = acc && (state_q == ST_B4);
  end

  // Continuity arithmetic on the staged winNum; the mod-256 gap is what a
  // duplicate or backwards step turns into, so a repeat adds 255.
  always_comb begin
    win      = stg_q[0];
    win_exp  = last_q + 8'd1;
    gap      = win - win_exp;
    drop_sum = SW'(ndrop_q) + SW'(gap);
  end

  always_comb begin
    state_d     = state_q;
    stg_d       = stg_q;
    tmo_d       = tmo_q;
    have_last_d = have_last_q;
    last_d      = last_q;
    valid_d     = valid_q;
    data_d      = data_q;
    seq_err_d   = seq_err_q;
    ndrop_d     = ndrop_q;
    abort_d     = 1'b0;

    if (valid_q && bus.i_pkt_ready) begin
      valid_d = 1'b0;
    end

    if (bus.i_flush) begin
      // Output slot and drop count survive a flush; only reassembly resyncs.
      state_d     = ST_B0;
      have_last_d = 1'b0;
      tmo_d       = '0;
    end else if (acc) begin
      tmo_d = '0;
      unique case (state_q)
        ST_B0: begin stg_d[0] = bus.i_bp_data; state_d = ST_B1; end
        ST_B1: begin stg_d[1] = bus.i_bp_data; state_d = ST_B2; end
        ST_B2: begin stg_d[2] = bus.i_bp_data; state_d = ST_B3; end
        ST_B3: begin stg_d[3] = bus.i_bp_data; state_d = ST_B4; end
        ST_B4: state_d = ST_B0;
        default: state_d = ST_B0;
      endcase
    end else if (state_q != ST_B0) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_B0;
        tmo_d   = '0;
        abort_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    if (complete) begin
      valid_d = 1'b1;
      // Last byte goes straight from the pipe to the output register.
      data_d  = {bus.i_bp_data, stg_q[3], stg_q[2], stg_q[1], stg_q[0]};
      if (!have_last_q) begin
        seq_err_d = 1'b0;
      end else begin
        seq_err_d = (win != win_exp);
        if (drop_sum > DROP_SAT) begin
          ndrop_d = '1;
        end else begin
          ndrop_d = drop_sum[DROPCOUNT_W-1:0];
        end
      end
      have_last_d = 1'b1;
      last_d      = win;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_B0;
      stg_q       <= '0;
      tmo_q       <= '0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      seq_err_q   <= 1'b0;
      ndrop_q     <= '0;
      abort_q     <= 1'b0;
    end else if (bus.i_cg) begin
      state_q     <= state_d;
      stg_q       <= stg_d;
      tmo_q       <= tmo_d;
      have_last_q <= have_last_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      seq_err_q   <= seq_err_d;
      ndrop_q     <= ndrop_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.o_bp_ready   = bp_ready;
  assign bus.o_pkt_valid  = valid_q;
  assign bus.o_pkt_data   = data_q;
  assign bus.o_pkt_seqErr = seq_err_q;
  assign bus.o_nDropped   = ndrop_q;
  assign bus.o_abort      = abort_q;

endmodule

// File: tb/tb_corr_pkt_decoder.sv
// tb_corr_pkt_decoder
//   Drives two decoders (16-bit and 4-bit drop counters) from one stimulus
//   stream and compares every cycle against a queue-based packet model.
module tb_corr_pkt_decoder;
  localparam int T = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  corr_pkt_decoder_if #(.DROPCOUNT_W(16)) bus ();
  corr_pkt_decoder_if #(.DROPCOUNT_W(4))  bus4 ();

  assign bus4.i_cg        = bus.i_cg;
  assign bus4.i_flush     = bus.i_flush;
  assign bus4.i_bp_data   = bus.i_bp_data;
  assign bus4.i_bp_valid  = bus.i_bp_valid;
  assign bus4.i_pkt_ready = bus.i_pkt_ready;

  corr_pkt_decoder #(.DROPCOUNT_W(16), .TIMEOUT_CYCLES(T)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  corr_pkt_decoder #(.DROPCOUNT_W(4), .TIMEOUT_CYCLES(T)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int abort_cnt = 0;

  // reference model state
  logic [7:0]  cur[$];
  bit          pend;
  logic [39:0] mdata;
  bit          merr;
  bit          have;
  int          last;
  int          idle;
  int          drop16;
  int          drop4;
  bit          mabort;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    pend = 0; mdata = '0; merr = 0; have = 0; last = 0;
    idle = 0; drop16 = 0; drop4 = 0; mabort = 0;
  endtask

  function automatic bit model_ready(input bit cg, input bit fl, input bit pr);
    return cg && !fl && (cur.size() != 4 || !pend || pr);
  endfunction

  task automatic model_step(input bit cg, input bit fl, input bit bv,
                            input logic [7:0] bd, input bit pr, output bit acc);
    bit done;
    int w, e, d;
    acc = 0;
    if (!cg) return;
    acc  = bv && model_ready(cg, fl, pr);
    done = 0;
    mabort = 0;
    if (pend && pr) pend = 0;
    if (fl) begin
      cur.delete(); have = 0; idle = 0;
    end else if (acc) begin
      cur.push_back(bd);
      idle = 0;
      if (cur.size() == 5) done = 1;
    end else if (cur.size() != 0) begin
      if (idle == T - 1) begin
        cur.delete(); idle = 0; mabort = 1;
      end else begin
        idle++;
      end
    end else begin
      idle = 0;
    end
    if (done) begin
      for (int i = 0; i < 5; i++) mdata[8*i +: 8] = cur[i];
      w = int'(cur[0]);
      if (!have) begin
        merr = 0;
      end else begin
        e = (last + 1) % 256;
        merr = (w != e);
        d = (w - e + 256) % 256;
        drop16 = (drop16 + d > 65535) ? 65535 : drop16 + d;
        drop4  = (drop4 + d > 15) ? 15 : drop4 + d;
      end
      have = 1;
      last = w;
      pend = 1;
      cur.delete();
    end
  endtask

  task automatic step(input bit r, input bit cg, input bit fl, input bit bv,
                      input logic [7:0] bd, input bit pr, output bit acc);
    @(negedge clk);
    rst = r;
    bus.i_cg = cg; bus.i_flush = fl; bus.i_bp_valid = bv;
    bus.i_bp_data = bd; bus.i_pkt_ready = pr;
    #1;
    if (r) model_reset();
    chk("pkt_valid", bus.o_pkt_valid, pend);
    if (pend) begin
      chk("pkt_data", bus.o_pkt_data, mdata);
      chk("pkt_seqErr", bus.o_pkt_seqErr, merr);
    end
    chk("nDropped16", bus.o_nDropped, drop16);
    chk("nDropped4", bus4.o_nDropped, drop4);
    chk("abort", bus.o_abort, mabort);
    chk("bp_ready", bus.o_bp_ready, model_ready(cg, fl, pr));
    if (bus.o_abort) abort_cnt++;
    acc = 0;
    if (!r) model_step(cg, fl, bv, bd, pr, acc);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pr);
    bit a;
    int n;
    n = 0;
    a = 0;
    while (!a && n < 40) begin
      step(0, 1, 0, 1, b, pr, a);
      n++;
    end
    chk("send_accept", a, 1);
  endtask

  task automatic send_pkt(input logic [39:0] p, input bit pr);
    for (int i = 0; i < 5; i++) send_byte(p[8*i +: 8], pr);
  endtask

  task automatic idle_cycles(input int n, input bit pr);
    bit a;
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 8'h00, pr, a);
  endtask

  task automatic do_reset();
    bit a;
    step(1, 1, 0, 0, 8'h00, 0, a);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit a;
    bus.i_cg = 1; bus.i_flush = 0; bus.i_bp_valid = 0;
    bus.i_bp_data = 0; bus.i_pkt_ready = 0;
    model_reset();

    // reset values
    do_reset();
    do_reset();

    // 1: basic stream, 1-cycle latency, back-to-back
    send_pkt(40'h4433221100, 1);
    peek();
    chk("t1_valid", bus.o_pkt_valid, 1);
    chk("t1_data", bus.o_pkt_data, 40'h4433221100);
    chk("t1_seqErr", bus.o_pkt_seqErr, 0);
    send_pkt(40'h9988776601, 1);
    peek();
    chk("t1_win2", bus.o_pkt_data[7:0], 8'h01);
    chk("t1_seqErr2", bus.o_pkt_seqErr, 0);
    chk("t1_drop", bus.o_nDropped, 0);
    idle_cycles(2, 1);

    // 2: gap of 3 then saturation on the 4-bit counter
    do_reset();
    send_pkt(40'hAAAAAAAA05, 1);
    send_pkt(40'hBBBBBBBB09, 1);
    peek();
    chk("t2_seqErr", bus.o_pkt_seqErr, 1);
    chk("t2_drop", bus.o_nDropped, 3);
    send_pkt(40'hCCCCCCCC1E, 1);
    peek();
    chk("t2_drop16", bus.o_nDropped, 23);
    chk("t2_sat4", bus4.o_nDropped, 15);
    idle_cycles(2, 1);

    // 3: back-pressure holds byte 4 of the second packet
    send_pkt(40'h0403020110, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'h77, 0, a);
    chk("t3_stall", bus.o_bp_ready, 0);
    chk("t3_hold", bus.o_pkt_data, 40'h0403020110);
    send_byte(8'h77, 1);
    peek();
    chk("t3_second", bus.o_pkt_data, 40'h7724232221);
    idle_cycles(2, 1);

    // 4: timeout of a 3-byte fragment
    send_byte(8'h12, 1); send_byte(8'h34, 1); send_byte(8'h56, 1);
    abort_cnt = 0;
    idle_cycles(T + 3, 1);
    chk("t4_abort_once", abort_cnt, 1);
    send_pkt(40'h5544332223, 1);
    peek();
    chk("t4_clean", bus.o_pkt_data, 40'h5544332223);
    idle_cycles(2, 1);

    // 5: flush forgets the last winNum
    do_reset();
    send_pkt(40'h1111111107, 1);
    step(0, 1, 1, 1, 8'h99, 1, a);
    send_pkt(40'h2222222242, 1);
    peek();
    chk("t5_noerr", bus.o_pkt_seqErr, 0);
    chk("t5_nodrop", bus.o_nDropped, 0);
    send_pkt(40'h3333333344, 1);
    peek();
    chk("t5_err", bus.o_pkt_seqErr, 1);
    chk("t5_drop", bus.o_nDropped, 1);

    // 6: reset mid-packet and mid-stall, then clock gating
    send_byte(8'h45, 1); send_byte(8'h01, 1);
    do_reset();
    send_pkt(40'hDEADBEEF00, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h01, 0);
    do_reset();
    chk("t6_valid", bus.o_pkt_valid, 0);
    send_pkt(40'h0102030405, 1);
    peek();
    chk("t6_data", bus.o_pkt_data, 40'h0102030405);
    send_byte(8'h06, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'hEE, 1, a);
    chk("t6_cg_ready", bus.o_bp_ready, 0);
    send_pkt(40'h0A0B0C0D00, 1);
    idle_cycles(3, 1);

    // randomized traffic
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        bit r, cg, fl, bv, pr;
        logic [7:0] bd;
        r  = ($urandom_range(0, 299) == 0);
        cg = ($urandom_range(0, 9) != 0);
        fl = ($urandom_range(0, 99) == 0);
        bv = (ph == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 8);
        pr = (ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 7);
        bd = (ph == 0 && cur.size() == 0) ? 8'((last + 1 + int'($urandom_range(0, 2))) % 256)
                                          : 8'($urandom);
        step(r, cg, fl, bv, bd, pr, a);
      end
    end
    idle_cycles(2, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
